// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the byte-addressed RAM controller.
//   SZ_BYTE / SZ_HALF / SZ_WORD : access size encodings (2'b11 also means word)
//   WAIT_MAX                    : largest supported wait-cycle count
//   CNT_W                       : width of the wait counter
//   state_e                     : controller FSM states
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_fmt.sv
// mem_fmt: combinational read formatter. Assembles four little-endian bytes
// into a 32-bit result and zero/sign-extends byte and halfword reads.
// Ports:
//   b0_i..b3_i : bytes at a, a+1, a+2, a+3
//   size_i     : access size (byte / halfword / word)
//   se_i       : 1 = sign-extend byte/halfword, ignored for words
//   word_o     : formatted 32-bit read value
module mem_fmt
    import mem_pkg::*;
(
    input  logic [7:0]  b0_i,
    input  logic [7:0]  b1_i,
    input  logic [7:0]  b2_i,
    input  logic [7:0]  b3_i,
    input  logic [1:0]  size_i,
    input  logic        se_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = {b3_i, b2_i, b1_i, b0_i};
        case (size_i)
            SZ_BYTE: word_o = {{24{se_i & b0_i[7]}}, b0_i};
            SZ_HALF: word_o = {{16{se_i & b1_i[7]}}, b1_i, b0_i};
            default: ;
        endcase
    end

endmodule

// File: rtl/sync_ram_ctrl.sv
// sync_ram_ctrl: byte-addressed RAM with a three-state access controller
// (IDLE -> WAIT -> DONE) and a programmable number of wait cycles.
// Optional build macro: ALIGN_CHECK_EN flags misaligned halfword/word
// accesses with err=1 and suppresses their effect; without it err is 0.
// Parameters:
//   ADDR_W : byte-address width, depth = 2**ADDR_W bytes
//   WAIT   : wait cycles per access (0..WAIT_MAX)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : access request, accepted only while ready=1
//   we, se     : write enable, sign-extend select for reads
//   size       : 00 byte, 01 halfword, 1x word
//   addr       : byte address (offsets wrap modulo depth)
//   wdata      : little-endian write data
//   ready      : high in IDLE
//   done       : one-cycle completion pulse
//   rdata      : last completed read result
//   err        : misalignment flag, meaningful while done=1
module sync_ram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned WAIT   = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic              se,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, se_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [7:0]        mem [DEPTH];

    logic              in_idle, accept, enter_done, acc_err, mem_wr;
    logic              a_we, a_se;
    logic [1:0]        a_size;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0]       a_wdata;
    logic [31:0]       fmt_word;

    assign in_idle = (state_q == ST_IDLE);
    assign accept  = in_idle && req;

    // With WAIT=0 the DONE-entry edge is the accepting edge itself, so the
    // access is taken from the live inputs in IDLE and from the latched
    // copies afterwards.
    assign a_we    = in_idle ? we    : we_q;
    assign a_se    = in_idle ? se    : se_q;
    assign a_size  = in_idle ? size  : size_q;
    assign a0      = in_idle ? addr  : addr_q;
    assign a_wdata = in_idle ? wdata : wdata_q;

    // Byte offsets wrap naturally in ADDR_W-bit arithmetic.
    assign a1 = a0 + ADDR_W'(1);
    assign a2 = a0 + ADDR_W'(2);
    assign a3 = a0 + ADDR_W'(3);

`ifdef ALIGN_CHECK_EN
    assign acc_err = ((a_size == SZ_HALF) && a0[0]) ||
                     (a_size[1] && (a0[1:0] != 2'b00));
`else
    assign acc_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cnt_d   = CNT_W'(WAIT);
                    state_d = (WAIT == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            se_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we;
                se_q    <= se;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (enter_done) begin
                err_q <= acc_err;
                if (!a_we && !acc_err) begin
                    rdata_q <= fmt_word;
                end
            end
        end
    end

    // rst_n gates the write so a WAIT=0 request seen during reset cannot commit.
    assign mem_wr = enter_done && a_we && !acc_err && rst_n;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[a0] <= a_wdata[7:0];
            if (a_size != SZ_BYTE) begin
                mem[a1] <= a_wdata[15:8];
            end
            if (a_size[1]) begin
                mem[a2] <= a_wdata[23:16];
                mem[a3] <= a_wdata[31:24];
            end
        end
    end

    mem_fmt u_fmt (
        .b0_i   (mem[a0]),
        .b1_i   (mem[a1]),
        .b2_i   (mem[a2]),
        .b3_i   (mem[a3]),
        .size_i (a_size),
        .se_i   (a_se),
        .word_o (fmt_word)
    );

    assign ready = in_idle;
    assign done  = (state_q == ST_DONE);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: doc/sync_ram_ctrl.md
SYNC_RAM_CTRL -- requirements
Module: sync_ram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, byte-address width; depth is 2**ADDR_W bytes.
REQ-002 The block SHALL have parameter WAIT, default 1, wait cycles per access, range 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 1 bit, access request.
REQ-006 The block SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL have port se, input, 1 bit, sign-extend select for byte and halfword reads.
REQ-008 The block SHALL have port size, input, 2 bits: 00 byte, 01 halfword, 10 and 11 word.
REQ-009 The block SHALL have port addr, input, ADDR_W bits, byte address.
REQ-010 The block SHALL have port wdata, input, 32 bits, write data, little-endian.
REQ-011 The block SHALL have port ready, output, 1 bit, high only in IDLE.
REQ-012 The block SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-013 The block SHALL have port rdata, output, 32 bits, read result.
REQ-014 The block SHALL have port err, output, 1 bit, error flag; valid only while done is high.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-016 In IDLE with req=1, the block SHALL latch we/se/size/addr/wdata, load the wait counter with WAIT, and go to WAIT, or go straight to DONE if WAIT=0.
REQ-017 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to DONE on the cycle it reads 1.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; done therefore rises WAIT+1 cycles after the accepting edge.
REQ-019 req while ready=0 SHALL be ignored; inputs changing after acceptance SHALL have no effect.
REQ-020 A write SHALL commit to the memory array on the DONE-entry edge: size 00 writes Mem[a]=wdata[7:0]; size 01 additionally writes Mem[a+1]=wdata[15:8]; word writes Mem[a..a+3] from wdata[7:0]..[31:24].
REQ-021 A read SHALL load rdata on the DONE-entry edge: byte is zero- or sign-extended by se from bit 7; halfword {Mem[a+1],Mem[a]} is extended from bit 15; word is {Mem[a+3],Mem[a+2],Mem[a+1],Mem[a]}; se is ignored for words.
REQ-022 rdata SHALL hold its value until the next completed read; writes SHALL leave rdata unchanged.
REQ-023 Byte offsets a+1..a+3 SHALL wrap modulo 2**ADDR_W (for example, word at 0x1FF uses 0x1FF,0x000,0x001,0x002).
REQ-024 req held high continuously SHALL yield back-to-back accesses: re-acceptance occurs on the first IDLE cycle after DONE.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously force state=IDLE, counter=0, ready=1, done=0, err=0, rdata=0.
REQ-026 Reset mid-access SHALL abort it: no write commits and rdata stays 0.
REQ-027 Memory array contents SHALL NOT be reset.

Configuration
REQ-028 With ALIGN_CHECK_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL complete with the same latency and err=1 in DONE, with no memory write and rdata unchanged.
REQ-029 Without ALIGN_CHECK_EN, misaligned accesses SHALL proceed per REQ-020/021/023, and err SHALL be tied to 0.

Structure
REQ-030 Shared package mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and the WAIT_MAX=15 constant.
REQ-031 Read extension and lane assembly SHALL live in a combinational sub-module mem_fmt (inputs: four bytes, size, se; output: 32-bit word); the FSM, counter and array SHALL stay in sync_ram_ctrl.

Verification
REQ-032 WAIT=1: write word 0xA1B2C3D4 at 0x010, then read word at 0x010 -> done 2 cycles after each accept, rdata=0xA1B2C3D4.
REQ-033 Read byte at 0x013 with se=1 -> 0xFFFFFFA1; with se=0 -> 0x000000A1; read halfword at 0x012 with se=1 -> 0xFFFFA1B2.
REQ-034 WAIT=0 with req held high for 3 accesses -> done pulses every 2 cycles, ready low in DONE.
REQ-035 Word write 0x11223344 at 0x1FF without ALIGN_CHECK_EN -> Mem[0x1FF]=0x44 and Mem[0x002]=0x11; with ALIGN_CHECK_EN -> err=1 at done and Mem unchanged.
REQ-036 rst_n pulsed low in WAIT during a write of 0xDEADBEEF to 0x020 -> outputs return to reset values immediately, Mem[0x020..0x023] unchanged, and the next req is accepted normally.
